spi_master: RTL and testbench

- Single-byte SPI master, mode 0 (CPOL=0, CPHA=0), MSB first, full duplex.
- Clocked by the 100 MHz system clock.
- SCK is derived by a programmable divider.
- Sits between a host controller (e.g. SD card / flash driver) and the external SPI pins: the host pulses start with a byte and receives the returned byte plus a one-cycle complete pulse.

---
 rtl/spi_master_if.sv | 32 +++
 rtl/spi_master.sv | 126 ++++++++++++
 tb/tb_spi_master.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/spi_master_if.sv
// Host/pin bundle for spi_master: start/byte handshake plus the SPI pins.
// The chip-select line exists only when SPI_MASTER_CS_EN is defined.
interface spi_master_if;
  logic       start;
  logic [7:0] tx_data;
  logic [7:0] rx_data;
  logic       complete;
  logic       sck;
  logic       mosi;
  logic       miso;
`ifdef SPI_MASTER_CS_EN
  logic       cs;
`endif

  // master: the spi_master block itself
  modport master (
`ifdef SPI_MASTER_CS_EN
    output cs,
`endif
    input  start, tx_data, miso,
    output rx_data, complete, sck, mosi
  );

  // slave: host and external device side of the same wires
  modport slave (
`ifdef SPI_MASTER_CS_EN
    input  cs,
`endif
    output start, tx_data, miso,
    input  rx_data, complete, sck, mosi
  );
endinterface

// File: rtl/spi_master.sv
// Single-byte SPI master, mode 0, MSB first, SCK = clk100 / (2*HALF_PERIOD).
// Optional active-low chip select enabled by defining SPI_MASTER_CS_EN.
module spi_master #(
  parameter int unsigned HALF_PERIOD = 100
) (
  input logic          clk100,
  input logic          reset,
  spi_master_if.master bus
);

  localparam int unsigned CW = (HALF_PERIOD > 1) ? $clog2(HALF_PERIOD) : 1;
  localparam logic [CW-1:0] DIV_LAST = CW'(HALF_PERIOD - 1);

  typedef enum logic {IDLE, XFER} state_t;

  state_t        state_reg, state_next;
  logic [CW-1:0] div_reg, div_next;
  logic [2:0]    bit_reg, bit_next;
  logic          last_reg, last_next;
  logic [7:0]    tx_reg, tx_next;
  logic [7:0]    rx_reg, rx_next;
  logic [7:0]    rx_data_reg, rx_data_next;
  logic          complete_reg, complete_next;
  logic          sck_reg, sck_next;
  logic          tick;
  logic          finish;
`ifdef SPI_MASTER_CS_EN
  logic          cs_reg, cs_next;
`endif

  always_ff @(posedge clk100 or posedge reset) begin
    if (reset) begin
      state_reg    <= IDLE;
      div_reg      <= '0;
      bit_reg      <= '0;
      last_reg     <= 1'b0;
      tx_reg       <= '0;
      rx_reg       <= '0;
      rx_data_reg  <= '0;
      complete_reg <= 1'b0;
      sck_reg      <= 1'b0;
`ifdef SPI_MASTER_CS_EN
      cs_reg       <= 1'b1;
`endif
    end else begin
      state_reg    <= state_next;
      div_reg      <= div_next;
      bit_reg      <= bit_next;
      last_reg     <= last_next;
      tx_reg       <= tx_next;
      rx_reg       <= rx_next;
      rx_data_reg  <= rx_data_next;
      complete_reg <= complete_next;
      sck_reg      <= sck_next;
`ifdef SPI_MASTER_CS_EN
      cs_reg       <= cs_next;
`endif
    end
  end

  always_comb begin
    state_next    = state_reg;
    div_next      = div_reg;
    bit_next      = bit_reg;
    last_next     = last_reg;
    tx_next       = tx_reg;
    rx_next       = rx_reg;
    rx_data_next  = rx_data_reg;
    complete_next = 1'b0;
    sck_next      = sck_reg;
    tick          = (div_reg == DIV_LAST);
    finish        = 1'b0;
`ifdef SPI_MASTER_CS_EN
    cs_next       = cs_reg;
`endif

    unique case (state_reg)
      IDLE: sck_next = 1'b0;
      XFER: begin
        div_next = tick ? '0 : div_reg + CW'(1);
        if (tick) begin
          sck_next = ~sck_reg;
          if (!sck_reg) begin
            rx_next = {rx_reg[6:0], bus.miso};
          end else if (last_reg) begin
            // eighth falling edge: tx_reg is left unshifted so mosi keeps the last bit
            finish        = 1'b1;
            rx_data_next  = rx_reg;
            complete_next = 1'b1;
            state_next    = IDLE;
`ifdef SPI_MASTER_CS_EN
            cs_next       = 1'b1;
`endif
          end else begin
            tx_next   = {tx_reg[6:0], 1'b0};
            bit_next  = bit_reg + 3'd1;
            last_next = (bit_reg == 3'd6);
          end
        end
      end
      default: state_next = IDLE;
    endcase

    // Accepting on the finishing edge lets transfers run back to back without a gap.
    if (bus.start && (state_reg == IDLE || finish)) begin
      state_next = XFER;
      tx_next    = bus.tx_data;
      div_next   = '0;
      bit_next   = '0;
      last_next  = 1'b0;
      sck_next   = 1'b0;
`ifdef SPI_MASTER_CS_EN
      cs_next    = 1'b0;
`endif
    end
  end

  assign bus.mosi     = tx_reg[7];
  assign bus.sck      = sck_reg;
  assign bus.complete = complete_reg;
  assign bus.rx_data  = rx_data_reg;
`ifdef SPI_MASTER_CS_EN
  assign bus.cs       = cs_reg;
`endif

endmodule

// File: tb/tb_spi_master.sv
// Self-checking bench for spi_master: table vectors, busy/back-to-back,
// mid-transfer reset and randomized transfers against a cycle-arithmetic model.
module tb_spi_master;
  localparam int H    = 100;
  localparam int XLEN = 16 * H;

  logic clk100 = 1'b0;
  logic reset  = 1'b1;
  int   passed = 0;
  int   total  = 0;

  spi_master_if bus();

  spi_master #(.HALF_PERIOD(H)) dut (
    .clk100 (clk100),
    .reset  (reset),
    .bus    (bus)
  );

  always #5 clk100 = ~clk100;

  typedef struct {
    logic [7:0] tx;
    logic [7:0] mb;
    bit         win;
    logic [7:0] exp_rx;
  } vec_t;

  vec_t vecs[4];

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual === expected) passed++;
    else $display("FAIL %s: got %0h, required %0h", name, actual, expected);
  endtask

  // miso level wanted at clk100 edge e of a transfer (edge 0 = start accepted)
  function automatic logic miso_at(input int e, input logic [7:0] mb, input bit win);
    if (win) return (e >= 1092 && e < 1108);
    if (e < 0 || e >= XLEN) return 1'b0;
    return mb[7 - e / (2 * H)];
  endfunction

  // Reference: the byte assembled from miso at each SCK rising edge (2k+1)*H
  function automatic logic [7:0] model_rx(input logic [7:0] mb, input bit win);
    logic [7:0] r = '0;
    for (int k = 0; k < 8; k++) r = {r[6:0], miso_at((2 * k + 1) * H, mb, win)};
    return r;
  endfunction

  // Runs one transfer and observes every cycle after edges 0..XLEN.
  // cont: edge 0 was already taken by a back-to-back start in the previous call.
  task automatic run_xfer(input logic [7:0] tx, input logic [7:0] mb, input bit win,
                          input logic [7:0] exp_rx, input bit cont, input bit busy,
                          input bit b2b, input logic [7:0] ntx, input string tag);
    int         sck_err    = 0;
    int         first_cpl  = -1;
    int         rx_changes = 0;
    int         cs_err     = 0;
    logic [7:0] mosi_bits  = '0;
    logic [7:0] rx0;
    logic [7:0] rx_end     = '0;
    if (!cont) begin
      bus.start   = 1'b1;
      bus.tx_data = tx;
      bus.miso    = miso_at(0, mb, win);
      @(posedge clk100);
      @(negedge clk100);
    end
    rx0 = bus.rx_data;
    for (int c = 0; c <= XLEN; c++) begin
      if (c > 0) begin
        @(posedge clk100);
        @(negedge clk100);
      end
      if (bus.sck !== ((c < XLEN) && ((c / H) % 2 == 1))) sck_err++;
      if (c < XLEN && (c / H) % 2 == 1 && c % H == 0) mosi_bits = {mosi_bits[6:0], bus.mosi};
      if (c > 0 && bus.complete === 1'b1 && first_cpl < 0) first_cpl = c;
      if (c > 0 && c < XLEN && bus.rx_data !== rx0) rx_changes++;
      if (c == XLEN) rx_end = bus.rx_data;
`ifdef SPI_MASTER_CS_EN
      if (c < XLEN) begin
        if (bus.cs !== 1'b0) cs_err++;
      end else if (bus.cs !== (b2b ? 1'b0 : 1'b1)) cs_err++;
`endif
      bus.start   = 1'b0;
      bus.tx_data = 8'($urandom);
      if (busy && c == 499) bus.start = 1'b1;
      if (b2b && c == XLEN - 1) begin
        bus.start   = 1'b1;
        bus.tx_data = ntx;
      end
      bus.miso = miso_at(c + 1, mb, win);
    end
    check($sformatf("%s sck_errors", tag), sck_err, 0);
    check($sformatf("%s mosi_bits", tag), mosi_bits, tx);
    check($sformatf("%s complete_cycle", tag), first_cpl, XLEN);
    check($sformatf("%s rx_data", tag), rx_end, exp_rx);
    check($sformatf("%s rx_early_changes", tag), rx_changes, 0);
`ifdef SPI_MASTER_CS_EN
    check($sformatf("%s cs_errors", tag), cs_err, 0);
`endif
  endtask

  initial begin
    logic [7:0] tx;
    logic [7:0] mb;
    logic [7:0] ntx;
    bit         nb;
    bit         prev_b2b;
    int         cpl_cnt;
    int         sck_cnt;

    vecs[0] = '{8'h8F, 8'h00, 1'b0, 8'h00};
    vecs[1] = '{8'h8F, 8'h00, 1'b1, 8'h04};
    vecs[2] = '{8'hA5, 8'hFF, 1'b0, 8'hFF};
    vecs[3] = '{8'h5A, 8'h3C, 1'b0, 8'h3C};

    bus.start   = 1'b0;
    bus.tx_data = 8'h00;
    bus.miso    = 1'b0;
    repeat (3) @(negedge clk100);
    check("reset sck/mosi/complete", {bus.sck, bus.mosi, bus.complete}, 3'b000);
    check("reset rx_data", bus.rx_data, 8'h00);
`ifdef SPI_MASTER_CS_EN
    check("reset cs", bus.cs, 1'b1);
`endif
    reset = 1'b0;
    repeat (2) @(negedge clk100);

    for (int i = 0; i < 4; i++) begin
      run_xfer(vecs[i].tx, vecs[i].mb, vecs[i].win, vecs[i].exp_rx, 1'b0, 1'b0, 1'b0, 8'h00,
               $sformatf("vec%0d", i));
      repeat (2) @(negedge clk100);
      check($sformatf("vec%0d idle sck/complete/mosi", i),
            {bus.sck, bus.complete, bus.mosi}, {2'b00, vecs[i].tx[0]});
`ifdef SPI_MASTER_CS_EN
      check($sformatf("vec%0d idle cs", i), bus.cs, 1'b1);
`endif
    end

    // Start at cycle 500 is ignored; start in the completing cycle chains 0x3C.
    run_xfer(8'h8F, 8'h00, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 8'h3C, "busy_first");
    run_xfer(8'h3C, 8'hC3, 1'b0, 8'hC3, 1'b1, 1'b0, 1'b0, 8'h00, "b2b_second");

    // Reset at cycle 700, just after SCK rising edge 3.
    bus.start   = 1'b1;
    bus.tx_data = 8'hF0;
    bus.miso    = 1'b1;
    @(posedge clk100);
    @(negedge clk100);
    bus.start = 1'b0;
    repeat (700) begin
      @(posedge clk100);
      @(negedge clk100);
    end
    check("pre-reset sck/mosi", {bus.sck, bus.mosi}, 2'b11);
    reset = 1'b1;
    #1;
    check("abort sck/mosi/complete", {bus.sck, bus.mosi, bus.complete}, 3'b000);
    check("abort rx_data", bus.rx_data, 8'h00);
`ifdef SPI_MASTER_CS_EN
    check("abort cs", bus.cs, 1'b1);
`endif
    repeat (3) @(negedge clk100);
    reset   = 1'b0;
    cpl_cnt = 0;
    sck_cnt = 0;
    repeat (1700) begin
      @(negedge clk100);
      if (bus.complete !== 1'b0) cpl_cnt++;
      if (bus.sck !== 1'b0) sck_cnt++;
    end
    check("post-abort complete pulses", cpl_cnt, 0);
    check("post-abort sck activity", sck_cnt, 0);
    run_xfer(8'h69, 8'h96, 1'b0, 8'h96, 1'b0, 1'b0, 1'b0, 8'h00, "after_abort");

    // Randomized transfers, some chained back to back.
    prev_b2b = 1'b0;
    tx       = 8'($urandom);
    for (int i = 0; i < 8; i++) begin
      mb  = 8'($urandom);
      nb  = (i < 7) && ($urandom_range(0, 1) == 1);
      ntx = 8'($urandom);
      run_xfer(tx, mb, 1'b0, model_rx(mb, 1'b0), prev_b2b, 1'b0, nb, ntx, $sformatf("rand%0d", i));
      prev_b2b = nb;
      if (nb) tx = ntx;
      else begin
        tx = 8'($urandom);
        repeat ($urandom_range(0, 3)) @(negedge clk100);
      end
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
